// File: rtl/scope_packetizer_pkg.sv
// Shared types for the scope packetizer.
//   packetizer_state_t : capture FSM states
//   packet_beat_t      : one buffered beat {data, dest, last}
// The beat field widths fix the data/dest widths of the whole block.
package scope_packetizer_pkg;

  localparam int BEAT_DATA_WIDTH = 32;
  localparam int BEAT_DEST_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } packetizer_state_t;

  typedef struct packed {
    logic [BEAT_DATA_WIDTH-1:0] data;
    logic [BEAT_DEST_WIDTH-1:0] dest;
    logic                       last;
  } packet_beat_t;

endpackage

// File: rtl/scope_packet_fifo.sv
// Synchronous first-word-fall-through FIFO of packet_beat_t.
// Ports:
//   clock, reset      system clock, synchronous active-high reset (empties FIFO)
//   wr_en, wr_beat    write request and beat; ignored while full
//   rd_en, rd_beat    read request and head beat; ignored while empty
//   full, empty       occupancy flags
//   level             current occupancy, 0..DEPTH
module scope_packet_fifo
  import scope_packetizer_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   wr_en,
  input  packet_beat_t           wr_beat,
  input  logic                   rd_en,
  output packet_beat_t           rd_beat,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  packet_beat_t mem [DEPTH];
  packet_beat_t hold_beat;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_wr;
  logic          do_rd;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign level = count;
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  // Once drained, the output keeps showing the last beat read rather than
  // whatever stale entry the read pointer now lands on.
  assign rd_beat = empty ? hold_beat : mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_beat;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      hold_beat <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_rd) begin
        rd_ptr    <= rd_ptr + AW'(1);
        hold_beat <= mem[rd_ptr];
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/scope_packetizer.sv
// Frames the combined scope sample stream into fixed-length packets, tagging
// tlast on every len-th captured beat, and buffers beats toward the DMA writer.
// Ports:
//   clock, reset            system clock, synchronous active-high reset
//   enable                  capture enable (level)
//   packet_length           beats per packet, latched at each packet start (0 acts as 1)
//   stream_in_*             combiner stream: data, dest, valid in; ready out
//   stream_out_*            buffered stream: data, dest, user(=0), tlast, valid out; ready in
//   packets_done            packets completed on stream_out (wraps)
//   fifo_level              buffer occupancy
//
// state | meaning
// IDLE  | not capturing; input beats accepted and dropped
// RUN   | capturing; beats framed into packets
// FLUSH | enable dropped mid-packet; capture until packet completes
module scope_packetizer
  import scope_packetizer_pkg::*;
#(
  parameter int DATA_WIDTH   = BEAT_DATA_WIDTH,
  parameter int DEST_WIDTH   = BEAT_DEST_WIDTH,
  parameter int FIFO_DEPTH   = 16,
  parameter int LENGTH_WIDTH = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [LENGTH_WIDTH-1:0]     packet_length,
  input  logic [DATA_WIDTH-1:0]       stream_in_data,
  input  logic [DEST_WIDTH-1:0]       stream_in_dest,
  input  logic                        stream_in_valid,
  output logic                        stream_in_ready,
  output logic [DATA_WIDTH-1:0]       stream_out_data,
  output logic [DEST_WIDTH-1:0]       stream_out_dest,
  output logic [7:0]                  stream_out_user,
  output logic                        stream_out_tlast,
  output logic                        stream_out_valid,
  input  logic                        stream_out_ready,
  output logic [31:0]                 packets_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  packetizer_state_t state, state_next;

  logic [LENGTH_WIDTH-1:0] beat_cnt;
  logic [LENGTH_WIDTH-1:0] len;
  logic [LENGTH_WIDTH-1:0] len_start;
  logic                    beat_last;
  logic                    wr_en;
  logic                    fifo_full;
  logic                    fifo_empty;
  packet_beat_t            wr_beat;
  packet_beat_t            rd_beat;

  assign len_start = (packet_length == '0) ? LENGTH_WIDTH'(1) : packet_length;
  assign beat_last = (beat_cnt == len - LENGTH_WIDTH'(1));

  assign wr_beat.data = stream_in_data;
  assign wr_beat.dest = stream_in_dest;
  assign wr_beat.last = beat_last;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next      = state;
    stream_in_ready = 1'b0;
    wr_en           = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          stream_in_ready = 1'b1;
          if (enable) begin
            state_next = RUN;
          end
        end
        RUN: begin
          stream_in_ready = !fifo_full;
          wr_en           = stream_in_valid && !fifo_full;
          if (!enable) begin
            // A packet just completed or never started: nothing to finish.
            if (wr_en) begin
              state_next = beat_last ? IDLE : FLUSH;
            end else begin
              state_next = (beat_cnt == '0) ? IDLE : FLUSH;
            end
          end
        end
        FLUSH: begin
          stream_in_ready = !fifo_full;
          wr_en           = stream_in_valid && !fifo_full;
          if (enable) begin
            state_next = RUN;
          end else if (wr_en && beat_last) begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      beat_cnt <= '0;
      len      <= LENGTH_WIDTH'(1);
    end else if (state == IDLE) begin
      if (enable) begin
        beat_cnt <= '0;
        len      <= len_start;
      end
    end else if (wr_en) begin
      if (beat_last) begin
        beat_cnt <= '0;
        len      <= len_start;
      end else begin
        beat_cnt <= beat_cnt + LENGTH_WIDTH'(1);
      end
    end
  end

  scope_packet_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_beat (wr_beat),
    .rd_en   (stream_out_ready),
    .rd_beat (rd_beat),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign stream_out_valid = !fifo_empty;
  assign stream_out_data  = rd_beat.data;
  assign stream_out_dest  = rd_beat.dest;
  assign stream_out_tlast = stream_out_valid && rd_beat.last;
  assign stream_out_user  = 8'h00;

  always_ff @(posedge clock) begin
    if (reset) begin
      packets_done <= '0;
    end else if (stream_out_valid && stream_out_ready && stream_out_tlast) begin
      packets_done <= packets_done + 32'd1;
    end
  end

endmodule
